// File: rtl/instr_fetch_unit.sv
// RISC-V fetch front end with a DEPTH-entry {pc, word} prefetch FIFO; IFU_BACKTOBACK_EN allows issue on the response cycle.
// Response-to-instr_valid latency is 1 cycle; fetch stalls while the FIFO is full and decode holds instr_ready low.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, req_pc;
  entry_t        fifo_mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, req_hs;

  assign instr_valid = reset && (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign head        = fifo_mem[rd_ptr];
  assign instr       = head.word;
  assign instr_pc    = head.pc;
  assign imem_addr   = fetch_pc;
  assign req_hs      = imem_req_valid && imem_req_ready;

`ifdef IFU_BACKTOBACK_EN
  // Occupancy after the response lands, used to decide same-cycle reissue.
  logic [CW:0] cnt_if_push;
  assign cnt_if_push = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
`endif

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    push           = 1'b0;
    if (reset) begin
      case (state)
        S_REQ: begin
          imem_req_valid = (count < DEPTH_C) && !redirect_valid;
          if (imem_req_valid && imem_req_ready) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            push      = !redirect_valid;
            state_nxt = S_REQ;
`ifdef IFU_BACKTOBACK_EN
            imem_req_valid = !redirect_valid && (cnt_if_push < (CW+1)'(DEPTH));
            if (imem_req_valid && imem_req_ready) state_nxt = S_WAIT;
`endif
          end else if (redirect_valid) begin
            state_nxt = S_DROP;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state_nxt = S_REQ;
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (req_hs) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + 32'd4;
        end
        // Push uses the pre-handshake req_pc: the word belongs to the older request.
        if (push) begin
          fifo_mem[wr_ptr] <= '{pc: req_pc, word: imem_rsp_data};
          wr_ptr           <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
`ifdef IFU_BACKTOBACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  typedef struct {
    logic        rdy, rsp, redir, irdy;
    logic [31:0] raddr, rpc;
    logic        erv, erv_b2b;
    logic [31:0] eaddr;
    logic        eiv;
    logic [31:0] epc;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rsp, input logic [31:0] raddr,
                              input logic redir, input logic [31:0] rpc, input logic irdy,
                              input logic erv, input logic erv_b2b, input logic [31:0] eaddr,
                              input logic eiv, input logic [31:0] epc);
    vec_t v;
    v.rdy = rdy; v.rsp = rsp; v.raddr = raddr; v.redir = redir; v.rpc = rpc; v.irdy = irdy;
    v.erv = erv; v.erv_b2b = erv_b2b; v.eaddr = eaddr; v.eiv = eiv; v.epc = epc;
    return v;
  endfunction

  task automatic idle_inputs();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
  endtask

  // Leaves reset asserted across one edge; the caller releases it at the next negedge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_req_valid2", 32'(imem_req_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  vec_t tbl [24];

  initial begin
    logic        prev_hs, erv, eiv, hs, pop, pending, stale;
    logic [31:0] prev_addr, nxt_addr, nxt_pc, m_next_pc, m_req_pc;
    int          mwait;
    ent_t        q [$];

    reset = 1'b0;
    idle_inputs();

    // fields: rdy rsp raddr | redir rpc irdy | erv erv_b2b eaddr | eiv epc
    tbl[0]  = mk(1, 0, 0,              0, 0,              0, 1, 1, 32'h0,          0, 0);
    tbl[1]  = mk(0, 1, 32'h0,          0, 0,              0, 0, 1, 32'h4,          0, 0);
    tbl[2]  = mk(1, 0, 0,              0, 0,              0, 1, 1, 32'h4,          1, 32'h0);
    tbl[3]  = mk(0, 1, 32'h4,          0, 0,              0, 0, 0, 0,              1, 32'h0);
    tbl[4]  = mk(1, 0, 0,              0, 0,              0, 0, 0, 0,              1, 32'h0);
    tbl[5]  = mk(1, 0, 0,              0, 0,              0, 0, 0, 0,              1, 32'h0);
    tbl[6]  = mk(1, 0, 0,              0, 0,              1, 0, 0, 0,              1, 32'h0);
    tbl[7]  = mk(1, 0, 0,              0, 0,              0, 1, 1, 32'h8,          1, 32'h4);
    tbl[8]  = mk(0, 1, 32'h8,          0, 0,              1, 0, 1, 32'hC,          1, 32'h4);
    tbl[9]  = mk(1, 0, 0,              0, 0,              1, 1, 1, 32'hC,          1, 32'h8);
    tbl[10] = mk(1, 0, 0,              1, 32'h103,        1, 0, 0, 0,              0, 0);
    tbl[11] = mk(1, 0, 0,              0, 0,              1, 0, 0, 0,              0, 0);
    tbl[12] = mk(1, 0, 0,              0, 0,              1, 0, 0, 0,              0, 0);
    tbl[13] = mk(1, 1, 32'hC,          0, 0,              1, 0, 0, 0,              0, 0);
    tbl[14] = mk(0, 0, 0,              0, 0,              1, 1, 1, 32'h100,        0, 0);
    tbl[15] = mk(1, 0, 0,              0, 0,              1, 1, 1, 32'h100,        0, 0);
    tbl[16] = mk(0, 1, 32'h100,        0, 0,              1, 0, 1, 32'h104,        0, 0);
    tbl[17] = mk(0, 0, 0,              0, 0,              0, 1, 1, 32'h104,        1, 32'h100);
    tbl[18] = mk(1, 0, 0,              0, 0,              0, 1, 1, 32'h104,        1, 32'h100);
    tbl[19] = mk(1, 1, 32'h104,        1, 32'hFFFF_FFFE,  0, 0, 0, 0,              1, 32'h100);
    tbl[20] = mk(1, 0, 0,              0, 0,              0, 1, 1, 32'hFFFF_FFFC,  0, 0);
    tbl[21] = mk(0, 1, 32'hFFFF_FFFC,  0, 0,              0, 0, 1, 32'h0,          0, 0);
    tbl[22] = mk(1, 0, 0,              0, 0,              1, 1, 1, 32'h0,          1, 32'hFFFF_FFFC);
    tbl[23] = mk(0, 0, 0,              0, 0,              1, 0, 0, 0,              0, 0);

    do_reset();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      reset          = 1'b1;
      imem_req_ready = tbl[i].rdy;
      imem_rsp_valid = tbl[i].rsp;
      imem_rsp_data  = data_of(tbl[i].raddr);
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      instr_ready    = tbl[i].irdy;
      #1;
      erv = B2B ? tbl[i].erv_b2b : tbl[i].erv;
      chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(erv));
      if (erv) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].eiv));
      if (tbl[i].eiv) begin
        chk($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), instr, data_of(tbl[i].epc));
      end
    end

    // Reset with a request outstanding, then an orphan response in REQ is ignored.
    do_reset();
    @(negedge clk);
    reset = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; instr_ready = 1'b1;
    #1;
    chk("orphan_req_valid", 32'(imem_req_valid), 32'd1);
    chk("orphan_addr", imem_addr, 32'h0);
    chk("orphan_instr_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #1;
    chk("orphan_instr_valid2", 32'(instr_valid), 32'd0);
    chk("orphan_req_valid2", 32'(imem_req_valid), 32'd1);
    chk("orphan_addr2", imem_addr, 32'h0);

    // Zero-wait memory throughput.
    do_reset();
    prev_hs = 1'b0; prev_addr = '0; nxt_addr = '0; nxt_pc = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      reset = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
      imem_rsp_valid = prev_hs;
      imem_rsp_data  = data_of(prev_addr);
      #1;
      erv = B2B ? 1'b1 : (c % 2 == 0);
      eiv = (c >= 2) && (B2B || (c % 2 == 0));
      chk($sformatf("tput%0d_req_valid", c), 32'(imem_req_valid), 32'(erv));
      chk($sformatf("tput%0d_instr_valid", c), 32'(instr_valid), 32'(eiv));
      if (imem_req_valid) begin
        chk($sformatf("tput%0d_addr", c), imem_addr, nxt_addr);
        nxt_addr += 32'd4;
      end
      if (instr_valid) begin
        chk($sformatf("tput%0d_instr_pc", c), instr_pc, nxt_pc);
        chk($sformatf("tput%0d_instr", c), instr, data_of(nxt_pc));
        nxt_pc += 32'd4;
      end
      prev_hs   = imem_req_valid;
      prev_addr = imem_addr;
    end

    // Randomized traffic against a queue-based reference model.
    do_reset();
    q.delete();
    m_next_pc = 32'h0; m_req_pc = '0; pending = 1'b0; stale = 1'b0; mwait = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset          = 1'b1;
      imem_rsp_valid = pending && (mwait == 0);
      imem_rsp_data  = imem_rsp_valid ? data_of(m_req_pc) : 32'($urandom);
      imem_req_ready = ($urandom % 4) != 0;
      instr_ready    = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = 32'($urandom);
      #1;
      eiv = q.size() != 0;
      pop = eiv && instr_ready;
      if (pending)
        erv = B2B && !stale && imem_rsp_valid && !redirect_valid &&
              (q.size() + 1 - (pop ? 1 : 0) < DEPTH);
      else
        erv = !redirect_valid && (q.size() < DEPTH);
      chk("rnd_req_valid", 32'(imem_req_valid), 32'(erv));
      if (erv) chk("rnd_addr", imem_addr, m_next_pc);
      chk("rnd_instr_valid", 32'(instr_valid), 32'(eiv));
      if (eiv) begin
        chk("rnd_instr_pc", instr_pc, q[0].pc);
        chk("rnd_instr", instr, q[0].w);
      end
      hs = erv && imem_req_ready;
      if (redirect_valid) begin
        q.delete();
        m_next_pc = redirect_pc & 32'hFFFF_FFFC;
        if (pending && imem_rsp_valid) begin
          pending = 1'b0; stale = 1'b0;
        end else if (pending) begin
          stale = 1'b1;
        end
      end else begin
        if (pop) void'(q.pop_front());
        if (pending && imem_rsp_valid) begin
          if (!stale) q.push_back('{pc: m_req_pc, w: imem_rsp_data});
          pending = 1'b0; stale = 1'b0;
        end
        if (hs) begin
          m_req_pc  = m_next_pc;
          m_next_pc = m_next_pc + 32'd4;
          pending   = 1'b1;
          mwait     = int'($urandom % 3);
        end
      end
      if (!hs && pending && mwait > 0) mwait--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end for the RISC-V core, sitting directly upstream of decode/ControlUnit. It drives the PC into instruction memory over a request/response handshake and buffers returned words with their PCs in a small prefetch FIFO. It hands them to decode over a valid/ready interface. It also accepts a branch/jump redirect that flushes the buffer and discards any in-flight stale response.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, prefetch FIFO entries; power of 2, ≥2

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  32  fetch address (word aligned)
- imem_rsp_valid  input  1  response data valid; only while a request is outstanding
- imem_rsp_data  input  32  instruction word
- redirect_valid  input  1  branch/jump taken; flush and refetch
- redirect_pc  input  32  new fetch address; bits [1:0] treated as 0
- instr_valid  output  1  head of FIFO valid
- instr_ready  input  1  decode consumes head
- instr  output  32  head instruction word
- instr_pc  output  32  PC of head instruction

## Operation
- Registers: fetch_pc, req_pc, state, FIFO of {pc, word} with count 0..DEPTH.
- States:
  - REQ: may issue.
  - WAIT: one request outstanding, response wanted.
  - DROP: one request outstanding, response stale.
- At most one outstanding request. The FIFO slot is reserved at issue, so a push never overflows.
- REQ:
  - imem_req_valid = (count < DEPTH) && !redirect_valid; imem_addr = fetch_pc.
  - On the req handshake: req_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 (mod 2^32), go WAIT.
- WAIT: on imem_rsp_valid, push {req_pc, imem_rsp_data} and go REQ.
- DROP: on imem_rsp_valid, discard data and go REQ.
- Pop when instr_valid && instr_ready. A simultaneous push and pop leaves count unchanged.
- Redirect has priority over push, pop and issue:
  - FIFO flushed (count ← 0); fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - WAIT with no rsp this cycle → DROP.
  - WAIT or DROP with rsp this cycle → response discarded, go REQ.
  - REQ → stays REQ; no request issued that cycle.
  - DROP with no rsp → stays DROP.
- instr_valid = (count != 0). instr and instr_pc come from the FIFO head and are held stable while instr_valid && !instr_ready.

## Timing
- Reset (reset=0 sampled at edge):
  - fetch_pc = RESET_PC, state = REQ, count = 0.
  - instr_valid = 0, imem_req_valid = 0 during reset; instr/instr_pc = 0.
- First request is asserted in the first cycle with reset=1.
- Response-to-instr_valid latency is 1 cycle: registered FIFO, no bypass.
- With a 0-wait memory (req accepted at cycle N, rsp at N+1), instr_valid rises at N+2.
- imem_req_valid must not depend on imem_req_ready. It may drop only on redirect or reset.
- Reset mid-operation discards the outstanding request state. The memory must tolerate an orphaned response, which is ignored in REQ.
- An imem_rsp_valid arriving in REQ is ignored. This is a protocol error with no state change.

## Configuration
- IFU_BACKTOBACK_EN:
  - Defined: in WAIT, when imem_rsp_valid arrives, the next request may issue in the same cycle if count + 1 < DEPTH (or count < DEPTH when a pop also occurs), and there is no redirect.
    - On that handshake the unit stays in WAIT with req_pc ← fetch_pc.
    - Gives 1 instruction/cycle with a 0-wait memory.
  - Undefined: requests issue only from REQ, so at most 1 instruction per 2 cycles.
  - Redirect, flush and DROP behaviour are identical in both builds.

## Test plan
- Reset release, RESET_PC=0, 0-wait memory, instr_ready=1 → addresses 0x0, 0x4, 0x8 issued in order. instr_pc 0x0, 0x4, 0x8 with matching words; first instr_valid 2 cycles after first req.
- instr_ready=0, DEPTH=2 → after 2 words buffered, imem_req_valid=0. Head stays 0x0 stable. Raising instr_ready resumes fetch at 0x8.
- Redirect to 0x103 while WAIT, response arriving 3 cycles later:
  - That response is dropped and FIFO is empty.
  - Next request is 0x100; instr_pc of the next delivered word is 0x100.
- Redirect in the same cycle as imem_rsp_valid → word discarded, state REQ. Next cycle requests redirect_pc.
- fetch_pc=0xFFFF_FFFC → next request address wraps to 0x0000_0000.
- IFU_BACKTOBACK_EN defined, 0-wait memory, instr_ready=1 → after warm-up, imem_req_valid and instr_valid both high every cycle. Undefined → each toggles every other cycle.
